// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory fetch port, redirect, and issue lanes.
//   im_addr/im_en/im_rdata   : aligned block fetch from async-read instruction memory
//   redirect/redirect_pc     : flush and restart fetch at a new PC
//   issue_take               : instructions consumed by the lanes this cycle
//   issue_valid/ir/pc, count : oldest ISSUE_W instructions and queue occupancy
// modport master is the queue side; modport slave is the memory/pipeline side.
interface fetch_queue_if #(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned IW      = 16,
    parameter int unsigned AW      = 9
);
    localparam int unsigned TW = $clog2(ISSUE_W) + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]         im_addr;
    logic                  im_en;
    logic [ISSUE_W*IW-1:0] im_rdata;
    logic                  redirect;
    logic [AW-1:0]         redirect_pc;
    logic [TW-1:0]         issue_take;
    logic [ISSUE_W-1:0]    issue_valid;
    logic [ISSUE_W*IW-1:0] issue_ir;
    logic [ISSUE_W*AW-1:0] issue_pc;
    logic [CW-1:0]         count;

    modport master (
        output im_addr, im_en, issue_valid, issue_ir, issue_pc, count,
        input  im_rdata, redirect, redirect_pc, issue_take
    );

    modport slave (
        input  im_addr, im_en, issue_valid, issue_ir, issue_pc, count,
        output im_rdata, redirect, redirect_pc, issue_take
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch/issue buffer: a circular queue filled with ISSUE_W-aligned
// blocks from instruction memory and drained by a variable per-cycle take count.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : fetch_queue_if.master (fetch port, redirect, issue lanes, occupancy)
module fetch_queue #(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned IW      = 16,
    parameter int unsigned AW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] OffMask = AW'(ISSUE_W - 1);

    logic [AW-1:0] fpc_q, fpc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [IW-1:0] ir_mem_q [DEPTH];
    logic [AW-1:0] pc_mem_q [DEPTH];

    logic [AW-1:0]      blk_addr;
    logic [AW-1:0]      off;
    logic               fetch;
    logic [CW-1:0]      n_enq;
    logic [CW-1:0]      take_ext;
    logic [CW-1:0]      take_eff;
    logic [ISSUE_W-1:0] wr_en;
    logic [PW-1:0]      wr_idx [ISSUE_W];
    logic [PW-1:0]      rd_idx [ISSUE_W];

    always_comb begin
        blk_addr = fpc_q & ~OffMask;
        off      = fpc_q & OffMask;
        // Free space judged on registered count only; same-cycle take is not credited.
        fetch    = rst && !bus.redirect && ((CW'(DEPTH) - count_q) >= CW'(ISSUE_W));
        n_enq    = fetch ? (CW'(ISSUE_W) - CW'(off)) : '0;
        take_ext = CW'(bus.issue_take);
        take_eff = (take_ext > count_q) ? count_q : take_ext;

        // Lanes below the fetch offset are skipped; the rest pack at tail in lane order.
        for (int l = 0; l < ISSUE_W; l++) begin
            wr_en[l]  = fetch && (AW'(l) >= off);
            wr_idx[l] = tail_q + PW'(l) - PW'(off);
        end

        if (bus.redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fpc_d   = bus.redirect_pc;
        end else begin
            head_d  = head_q + PW'(take_eff);
            tail_d  = tail_q + PW'(n_enq);
            count_d = count_q + n_enq - take_eff;
            fpc_d   = fetch ? (blk_addr + AW'(ISSUE_W)) : fpc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: unoccupied entries are never presented.
    always_ff @(posedge clk) begin
        for (int l = 0; l < ISSUE_W; l++) begin
            if (wr_en[l]) begin
                ir_mem_q[wr_idx[l]] <= bus.im_rdata[l*IW +: IW];
                pc_mem_q[wr_idx[l]] <= blk_addr + AW'(l);
            end
        end
    end

    always_comb begin
        bus.im_addr     = blk_addr;
        bus.im_en       = fetch;
        bus.count       = count_q;
        bus.issue_valid = '0;
        bus.issue_ir    = '0;
        bus.issue_pc    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_idx[i] = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                bus.issue_valid[i]        = 1'b1;
                bus.issue_ir[i*IW +: IW]  = ir_mem_q[rd_idx[i]];
                bus.issue_pc[i*AW +: AW]  = pc_mem_q[rd_idx[i]];
            end
        end
    end
endmodule
